boundary_scan_register: RTL and testbench

//   Parametrised boundary-scan data register with a 1-bit bypass register, both on one chain.

---
 rtl/boundary_scan_register.sv | 78 +++++++
 tb/tb_boundary_scan_register.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/boundary_scan_register.sv
// Boundary-scan data register plus 1-bit bypass on a single chain, clocked by TCK.
// Capture/shift/update are synchronous enables; the mode muxes sit between pins and core.
module boundary_scan_register #(
  parameter int N_IN  = 34,
  parameter int N_OUT = 17,
  parameter int CW    = 8
) (
  input  logic              TCK,
  input  logic              Reset,
  input  logic              TDI,
  input  logic              CaptureDR,
  input  logic              ShiftDR,
  input  logic              UpdateDR,
  input  logic [1:0]        Instr,
  input  logic [N_IN-1:0]   sys_in,
  output logic [N_IN-1:0]   core_in,
  input  logic [N_OUT-1:0]  core_out,
  output logic [N_OUT-1:0]  sys_out,
  output logic              TDO,
  output logic [CW-1:0]     shift_count,
  output logic              length_ok
);

  localparam int L = N_IN + N_OUT;
  localparam logic [CW-1:0] L_CW    = CW'(L);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  localparam logic [1:0] I_BYPASS = 2'b00;
  localparam logic [1:0] I_EXTEST = 2'b10;
  localparam logic [1:0] I_INTEST = 2'b11;

  logic [L-1:0]  sh_q, sh_d;
  logic [L-1:0]  up_q, up_d;
  logic          byp_q, byp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bypass;

  assign bypass = (Instr == I_BYPASS);

  always_comb begin
    sh_d  = sh_q;
    up_d  = up_q;
    byp_d = byp_q;
    cnt_d = cnt_q;
    // Capture wins over shift; update always sees the pre-edge shift stage.
    if (CaptureDR) begin
      cnt_d = '0;
      if (bypass) byp_d = 1'b0;
      else        sh_d  = {core_out, sys_in};
    end else if (ShiftDR) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
      if (bypass) byp_d = TDI;
      else        sh_d  = {sh_q[L-2:0], TDI};
    end
    if (UpdateDR && !bypass) up_d = sh_q;
  end

  always_ff @(posedge TCK or posedge Reset) begin
    if (Reset) begin
      sh_q  <= '0;
      up_q  <= '0;
      byp_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      up_q  <= up_d;
      byp_q <= byp_d;
      cnt_q <= cnt_d;
    end
  end

  assign TDO         = bypass ? byp_q : sh_q[L-1];
  assign core_in     = (Instr == I_INTEST) ? up_q[N_IN-1:0] : sys_in;
  assign sys_out     = (Instr == I_EXTEST) ? up_q[L-1:N_IN] : core_out;
  assign shift_count = cnt_q;
  assign length_ok   = (cnt_q == L_CW);

endmodule

// File: tb/tb_boundary_scan_register.sv
// Self-checking bench for boundary_scan_register (N_IN=4, N_OUT=2, CW=4) against a
// cell-level reference model of the chain, update stage, bypass bit and shift counter.
module tb_boundary_scan_register;
  localparam int N_IN  = 4;
  localparam int N_OUT = 2;
  localparam int CW    = 4;
  localparam int L     = N_IN + N_OUT;
  localparam int SAT   = 15;

  logic             TCK = 1'b0;
  logic             Reset, TDI, CaptureDR, ShiftDR, UpdateDR;
  logic [1:0]       Instr;
  logic [N_IN-1:0]  sys_in, core_in;
  logic [N_OUT-1:0] core_out, sys_out;
  logic             TDO;
  logic [CW-1:0]    shift_count;
  logic             length_ok;

  int checks = 0;
  int errors = 0;

  bit m_sh[L];
  bit m_up[L];
  bit m_byp;
  int m_cnt;

  boundary_scan_register #(.N_IN(N_IN), .N_OUT(N_OUT), .CW(CW)) dut (
    .TCK(TCK), .Reset(Reset), .TDI(TDI), .CaptureDR(CaptureDR), .ShiftDR(ShiftDR),
    .UpdateDR(UpdateDR), .Instr(Instr), .sys_in(sys_in), .core_in(core_in),
    .core_out(core_out), .sys_out(sys_out), .TDO(TDO), .shift_count(shift_count),
    .length_ok(length_ok)
  );

  always #5 TCK = ~TCK;

  task automatic model_clear();
    for (int k = 0; k < L; k++) begin m_sh[k] = 0; m_up[k] = 0; end
    m_byp = 0;
    m_cnt = 0;
  endtask

  task automatic model_edge();
    bit pre[L];
    pre = m_sh;
    if (Reset) begin model_clear(); return; end
    if (CaptureDR) begin
      m_cnt = 0;
      if (Instr == 2'b00) m_byp = 0;
      else for (int k = 0; k < L; k++) m_sh[k] = (k < N_IN) ? sys_in[k] : core_out[k-N_IN];
    end else if (ShiftDR) begin
      if (m_cnt < SAT) m_cnt++;
      if (Instr == 2'b00) m_byp = TDI;
      else begin
        for (int k = L-1; k > 0; k--) m_sh[k] = pre[k-1];
        m_sh[0] = TDI;
      end
    end
    if (UpdateDR && Instr != 2'b00) m_up = pre;
  endtask

  function automatic logic exp_tdo();
    return (Instr == 2'b00) ? m_byp : m_sh[L-1];
  endfunction

  function automatic logic [N_IN-1:0] exp_core_in();
    logic [N_IN-1:0] v;
    v = sys_in;
    if (Instr == 2'b11) for (int i = 0; i < N_IN; i++) v[i] = m_up[i];
    return v;
  endfunction

  function automatic logic [N_OUT-1:0] exp_sys_out();
    logic [N_OUT-1:0] v;
    v = core_out;
    if (Instr == 2'b10) for (int j = 0; j < N_OUT; j++) v[j] = m_up[N_IN+j];
    return v;
  endfunction

  task automatic tick();
    @(posedge TCK);
    model_edge();
    #1;
  endtask

  task automatic idle();
    CaptureDR = 0; ShiftDR = 0; UpdateDR = 0; TDI = 0;
  endtask

  task automatic test_reset();
    Reset = 1; idle(); Instr = 2'b10; sys_in = 4'hF; core_out = 2'b11;
    model_clear();
    tick(); tick();
    #1;
    checks++; if (TDO !== 1'b0) begin errors++; $display("FAIL reset_tdo got %b exp 0", TDO); end
    checks++; if (length_ok !== 1'b0) begin errors++; $display("FAIL reset_len got %b exp 0", length_ok); end
    checks++; if (shift_count !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", shift_count); end
    checks++; if (sys_out !== 2'b00) begin errors++; $display("FAIL reset_extest_sys_out got %b exp 00", sys_out); end
    Instr = 2'b11; #1;
    checks++; if (core_in !== 4'b0000) begin errors++; $display("FAIL reset_intest_core_in got %b exp 0000", core_in); end
    Instr = 2'b01; #1;
    checks++; if (core_in !== sys_in) begin errors++; $display("FAIL reset_sample_core_in got %b exp %b", core_in, sys_in); end
    Reset = 0; #1;
  endtask

  task automatic test_sample();
    Instr = 2'b01; sys_in = 4'b1010; core_out = 2'b01;
    CaptureDR = 1; tick(); CaptureDR = 0;
    ShiftDR = 1;
    for (int s = 0; s < L; s++) begin
      TDI = 1'($urandom); #1;
      checks++; if (TDO !== exp_tdo()) begin errors++; $display("FAIL sample_tdo shift %0d got %b exp %b", s, TDO, exp_tdo()); end
      tick();
    end
    ShiftDR = 0; #1;
    checks++; if (length_ok !== 1'b1 || shift_count !== 4'(L)) begin
      errors++; $display("FAIL sample_length got ok=%b cnt=%0d exp ok=1 cnt=%0d", length_ok, shift_count, L);
    end
  endtask

  task automatic preload_110011();
    logic [L-1:0] pat;
    pat = 6'b110011;
    Instr = 2'b01; ShiftDR = 1;
    for (int k = L-1; k >= 0; k--) begin TDI = pat[k]; tick(); end
    ShiftDR = 0; UpdateDR = 1; tick(); UpdateDR = 0;
  endtask

  task automatic test_extest();
    preload_110011();
    Instr = 2'b10;
    for (int r = 0; r < 4; r++) begin
      sys_in = 4'($urandom); core_out = 2'($urandom); #1;
      checks++; if (sys_out !== 2'b11 || sys_out !== exp_sys_out()) begin
        errors++; $display("FAIL extest_sys_out got %b exp 11", sys_out);
      end
      checks++; if (core_in !== sys_in) begin errors++; $display("FAIL extest_core_in got %b exp %b", core_in, sys_in); end
    end
  endtask

  task automatic test_intest();
    preload_110011();
    Instr = 2'b11;
    for (int r = 0; r < 4; r++) begin
      sys_in = 4'($urandom); core_out = 2'($urandom); #1;
      checks++; if (core_in !== 4'b0011 || core_in !== exp_core_in()) begin
        errors++; $display("FAIL intest_core_in got %b exp 0011", core_in);
      end
      checks++; if (sys_out !== core_out) begin errors++; $display("FAIL intest_sys_out got %b exp %b", sys_out, core_out); end
    end
  endtask

  task automatic test_bypass();
    logic [2:0] bits;
    bits = 3'b101;
    Instr = 2'b00;
    CaptureDR = 1; tick(); CaptureDR = 0; #1;
    checks++; if (TDO !== 1'b0) begin errors++; $display("FAIL bypass_capture_tdo got %b exp 0", TDO); end
    ShiftDR = 1;
    for (int b = 2; b >= 0; b--) begin
      TDI = bits[b]; tick(); TDI = ~bits[b]; #1;
      checks++; if (TDO !== bits[b] || TDO !== exp_tdo()) begin
        errors++; $display("FAIL bypass_tdo got %b exp %b", TDO, bits[b]);
      end
    end
    ShiftDR = 0; UpdateDR = 1; tick(); UpdateDR = 0;
    Instr = 2'b10; core_out = 2'b00; #1;
    checks++; if (sys_out !== exp_sys_out()) begin errors++; $display("FAIL bypass_update_sys_out got %b exp %b", sys_out, exp_sys_out()); end
    Instr = 2'b01; #1;
    checks++; if (TDO !== exp_tdo()) begin errors++; $display("FAIL bypass_sh_kept got %b exp %b", TDO, exp_tdo()); end
  endtask

  task automatic test_priority();
    Instr = 2'b01; sys_in = 4'($urandom); core_out = 2'($urandom);
    ShiftDR = 1; TDI = 1;
    tick(); tick(); tick();
    CaptureDR = 1; tick(); CaptureDR = 0; #1;
    checks++; if (shift_count !== 4'd0) begin errors++; $display("FAIL prio_cnt got %0d exp 0", shift_count); end
    checks++; if (TDO !== core_out[N_OUT-1]) begin errors++; $display("FAIL prio_capture_tdo got %b exp %b", TDO, core_out[N_OUT-1]); end
    for (int n = 1; n <= 20; n++) begin
      TDI = 1'($urandom); tick();
      checks++; if (shift_count !== 4'((n > SAT) ? SAT : n) || length_ok !== (n == L)) begin
        errors++; $display("FAIL sat_cnt n=%0d got cnt=%0d ok=%b exp cnt=%0d", n, shift_count, length_ok, (n > SAT) ? SAT : n);
      end
    end
    ShiftDR = 0;
  endtask

  task automatic test_reset_mid();
    logic [N_IN-1:0] si;
    logic [N_OUT-1:0] co;
    logic [L-1:0] cap;
    preload_110011();
    Instr = 2'b10; ShiftDR = 1;
    for (int s = 0; s < 3; s++) begin TDI = 1'($urandom); tick(); end
    #2 Reset = 1; model_clear(); #1;
    checks++; if (sys_out !== 2'b00 || TDO !== 1'b0) begin
      errors++; $display("FAIL midreset got sys_out=%b tdo=%b exp 00/0", sys_out, TDO);
    end
    tick(); Reset = 0; ShiftDR = 0;
    si = 4'($urandom); co = 2'($urandom); cap = {co, si};
    Instr = 2'b01; sys_in = si; core_out = co;
    CaptureDR = 1; tick(); CaptureDR = 0; ShiftDR = 1;
    for (int s = 0; s < L; s++) begin
      #1;
      checks++; if (TDO !== cap[L-1-s] || TDO !== exp_tdo()) begin
        errors++; $display("FAIL recapture_tdo shift %0d got %b exp %b", s, TDO, cap[L-1-s]);
      end
      tick();
    end
    ShiftDR = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) Instr = 2'($urandom);
      sys_in    = 4'($urandom);
      core_out  = 2'($urandom);
      TDI       = 1'($urandom);
      CaptureDR = ($urandom_range(0, 9) == 0);
      ShiftDR   = ($urandom_range(0, 3) != 0);
      UpdateDR  = ($urandom_range(0, 7) == 0);
      Reset     = ($urandom_range(0, 79) == 0);
      if (Reset) model_clear();
      #1;
      checks++; if (TDO !== exp_tdo() || core_in !== exp_core_in() || sys_out !== exp_sys_out()
                    || shift_count !== 4'(m_cnt) || length_ok !== (m_cnt == L)) begin
        errors++;
        $display("FAIL random c=%0d got tdo=%b ci=%b so=%b cnt=%0d ok=%b exp tdo=%b ci=%b so=%b cnt=%0d ok=%b",
                 c, TDO, core_in, sys_out, shift_count, length_ok,
                 exp_tdo(), exp_core_in(), exp_sys_out(), m_cnt, m_cnt == L);
      end
      tick();
      Reset = 0;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_sample();
    test_extest();
    test_intest();
    test_bypass();
    test_priority();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
